uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, ipclk cycles per serial bit; legal values are integers >= 4.
REQ-002 ipclk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx  input  1  serial line, asynchronous to ipclk; idle high.
REQ-005 dataout  output  8  last received byte.
REQ-006 valid  output  1  dataout holds an unconsumed byte.
REQ-007 ack  input  1  consumer accepts the byte.
REQ-008 frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-009 overrun  output  1  one-cycle pulse when a byte is lost because valid is still high.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 The frame SHALL be: start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-012 rx SHALL pass through a 2-flop synchronizer (reset value 1); all logic uses only the synchronized value, rxs.
REQ-013 States SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: on rxs==0 -> START, with the bit counter cleared. H = CLKS_PER_BIT/2, rounded down.
REQ-015 START: at count H-1 sample rxs; 0 -> DATA with bitpos=0 and counter cleared; 1 -> IDLE (false start), with no output change.
REQ-016 DATA: every CLKS_PER_BIT cycles sample rxs into shift bit bitpos and increment bitpos; after bitpos 7 -> STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles sample rxs; 1 -> deliver byte and -> IDLE; 0 -> pulse frame_err, discard byte, -> BREAK.
REQ-018 BREAK: stay until rxs==1, then -> IDLE; this prevents a held-low line from being read as back-to-back frames.
REQ-019 Delivery: dataout and valid SHALL update on the stop-sample edge; valid first reads high 2+H+9*CLKS_PER_BIT cycles after the rx pin falls.
REQ-020 valid SHALL stay high, and dataout stable, until ack is sampled high; valid clears on that edge.
REQ-021 ack while valid is low SHALL be ignored.
REQ-022 If delivery occurs while valid=1 and ack=0, then overrun pulses, the new byte is discarded, dataout is retained, and valid stays 1.
REQ-023 If delivery and ack coincide, then the new byte loads, valid stays 1, and overrun stays 0.
REQ-024 frame_err and overrun SHALL each be high for exactly one cycle per event.

Reset
REQ-025 On rst_n low, immediately: state=IDLE; dataout=8'h00; valid, frame_err, overrun, busy=0; counters=0; synchronizer flops=1.
REQ-026 Reset mid-frame SHALL abandon the partial frame with no output pulse; after rst_n rises, the next full frame SHALL be received correctly.

Structure
REQ-027 Shared package uart_pkg holds the state encoding, DATA_BITS=8, and START_BIT/STOP_BIT level constants, shared with the transmitter.
REQ-028 The synchronizer SHALL be the sub-module uart_sync (2-flop, async active-low reset to 1).
REQ-029 The bit counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL never wrap inside a bit.

Verification (CLKS_PER_BIT=16)
REQ-030 Frame 0xA5, ack held 0: dataout=8'hA5, valid rises 154 cycles after the rx falling edge and stays high; frame_err=0.
REQ-031 rx low pulse of 4 cycles: no valid, no frame_err, back in IDLE (busy=0) within 12 cycles.
REQ-032 Frame 0x3C with stop bit 0, rx then held low for 100 cycles: one frame_err pulse, valid=0, busy=1 until rx returns high, then 0x55 received correctly.
REQ-033 Frames 0x11 then 0x22 with no ack: overrun pulses once, dataout=8'h11; ack -> valid=0. Repeat with ack on the 0x22 stop-sample edge: dataout=8'h22, valid=1, no overrun.
REQ-034 rst_n low during data bit 4 of 0xF0: all outputs reset at once; after release, frame 0x0F gives dataout=8'h0F with valid high.
REQ-035 Back-to-back frames 0x00 and 0xFF with ack pulsed after each: both bytes delivered in order with no error pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART receiver and transmitter: receiver state
// encoding, data-bit count and the line levels of the start and stop bits.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS = 8;

  // Line levels: the start bit pulls the idle-high line low, the stop bit
  // returns it high.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_sync.sv
// -----------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer that brings the asynchronous serial line into the
// ipclk domain. Both flops reset to 1 so a reset never looks like a start bit.
//
// Ports:
//   ipclk  in   clock
//   rst_n  in   asynchronous active-low reset
//   d      in   asynchronous input (serial line)
//   q      out  synchronized copy of d, two cycles of latency
// -----------------------------------------------------------------------------
module uart_sync (
  input  logic ipclk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state is always written with non-blocking assignments
  // so every flop samples the values from before the clock edge.
  always_ff @(posedge ipclk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule : uart_sync

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 UART receiver. The line is synchronized, the start bit is qualified at
// its midpoint, and every following bit is sampled one bit period later,
// i.e. near the middle of each bit. A received byte is held in dataout with
// valid high until the consumer acknowledges it.
//
// Parameters:
//   CLKS_PER_BIT  ipclk cycles per serial bit (>= 4)
//
// Ports:
//   ipclk      in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   rx         in   serial line (asynchronous, idle high)
//   dataout    out  last delivered byte
//   valid      out  dataout holds an unconsumed byte
//   ack        in   consumer accepts the byte (ignored while valid is low)
//   frame_err  out  one-cycle pulse: stop bit sampled low
//   overrun    out  one-cycle pulse: byte dropped because valid was still high
//   busy       out  receiver is anywhere but IDLE
// -----------------------------------------------------------------------------
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 ipclk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dataout,
  output logic                 valid,
  input  logic                 ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int BITPOS_W = $clog2(DATA_BITS);

  // Terminal counts: the start bit is checked half a bit after the falling
  // edge, everything afterwards a full bit period apart.
  localparam logic [CNT_W-1:0]    HALF_LAST   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]    BIT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BITPOS_W-1:0] BITPOS_LAST = BITPOS_W'(DATA_BITS - 1);

  logic rxs;

  uart_sync u_sync (
    .ipclk (ipclk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs)
  );

  uart_state_e          state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [BITPOS_W-1:0]  bitpos_q,    bitpos_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] data_q,      data_d;
  logic                 valid_q,     valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;
  logic                 deliver;

  always_ff @(posedge ipclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bitpos_q    <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitpos_q    <= bitpos_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bitpos_d    = bitpos_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    // Consumer handshake; an ack with nothing pending has no effect.
    if (valid_q && ack) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (rxs == START_BIT) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rxs == START_BIT) begin
            state_d  = ST_DATA;
            bitpos_d = '0;
          end else begin
            // Line went back high before mid-bit: a glitch, not a frame.
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shift_d[bitpos_q] = rxs;
          bitpos_d         = bitpos_q + BITPOS_W'(1);
          if (bitpos_q == BITPOS_LAST) begin
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs == STOP_BIT) begin
            deliver = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_BREAK: begin
        // Wait out a held-low line so it is not decoded as endless frames.
        if (rxs == STOP_BIT) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new byte may replace the pending one only if the consumer takes the
    // pending one on this very edge; otherwise the new byte is dropped.
    if (deliver) begin
      if (valid_q && !ack) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end
  end

  assign dataout   = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule : uart_receiver

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Self-checking bench for uart_receiver with CLKS_PER_BIT = 16. Inputs change
// on the falling clock edge; outputs are read on the falling edge or 1 ns
// after the rising edge. frame_err/overrun are counted in high cycles, so a
// pulse that is too long shows up as an extra event.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       ipclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic       ack   = 1'b0;
  logic [7:0] dataout;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .ipclk     (ipclk),
    .rst_n     (rst_n),
    .rx        (rx),
    .dataout   (dataout),
    .valid     (valid),
    .ack       (ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 ipclk = ~ipclk;

  always @(negedge ipclk) begin
    if (frame_err === 1'b1) fe_cnt++;
    if (overrun === 1'b1)   ov_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_dout;
    logic       exp_valid;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Full frame starting at the current falling edge; returns on the falling
  // edge at the end of the stop bit. rx is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge ipclk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge ipclk);
    end
    rx = stop;
    repeat (CPB) @(negedge ipclk);
  endtask

  // Same frame, with ack high for exactly the stop-sample rising edge, which
  // falls 154 rising edges after the start bit is driven.
  task automatic send_frame_ack_at_stop(input logic [7:0] b);
    rx = 1'b0;
    repeat (CPB) @(negedge ipclk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge ipclk);
    end
    rx = 1'b1;
    repeat (10) @(negedge ipclk);
    ack = 1'b1;
    @(negedge ipclk);
    ack = 1'b0;
    repeat (CPB - 11) @(negedge ipclk);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge ipclk);
    ack = 1'b0;
  endtask

  initial begin
    int fe0;
    int ov0;
    int lat;
    logic [7:0] got[$];

    vecs[0] = '{8'h5A, 1'b1, 8'h5A, 1'b1, 0};
    vecs[1] = '{8'h01, 1'b1, 8'h01, 1'b1, 0};
    vecs[2] = '{8'h80, 1'b1, 8'h80, 1'b1, 0};
    vecs[3] = '{8'h3C, 1'b0, 8'h80, 1'b0, 1};
    vecs[4] = '{8'hC3, 1'b1, 8'hC3, 1'b1, 0};
    vecs[5] = '{8'hFE, 1'b1, 8'hFE, 1'b1, 0};

    // ---- reset state ----
    repeat (3) @(negedge ipclk);
    check("reset dataout", 32'(dataout), 32'h00);
    check("reset valid", 32'(valid), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge ipclk);

    // ---- 0xA5: latency from rx falling to valid, then valid holds ----
    fe0 = fe_cnt;
    lat = -1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        int n = 0;
        for (int i = 0; i < 400; i++) begin
          @(posedge ipclk);
          #1;
          if (valid === 1'b1) begin
            lat = n;
            break;
          end
          n++;
        end
      end
    join
    check("A5 latency", 32'(lat), 32'd154);
    repeat (50) @(negedge ipclk);
    check("A5 dataout", 32'(dataout), 32'hA5);
    check("A5 valid held", 32'(valid), 32'h1);
    check("A5 no frame_err", 32'(fe_cnt - fe0), 32'd0);
    pulse_ack();
    check("A5 ack clears valid", 32'(valid), 32'h0);

    // ---- ack with nothing pending is ignored ----
    pulse_ack();
    repeat (2) @(negedge ipclk);
    check("idle ack valid", 32'(valid), 32'h0);
    check("idle ack dataout", 32'(dataout), 32'hA5);

    // ---- table-driven frames ----
    for (int v = 0; v < 6; v++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      send_frame(vecs[v].data, vecs[v].stop);
      rx = 1'b1;
      repeat (4) @(negedge ipclk);
      check($sformatf("vec%0d dataout", v), 32'(dataout), 32'(vecs[v].exp_dout));
      check($sformatf("vec%0d valid", v), 32'(valid), 32'(vecs[v].exp_valid));
      check($sformatf("vec%0d frame_err", v), 32'(fe_cnt - fe0), 32'(vecs[v].exp_fe));
      check($sformatf("vec%0d overrun", v), 32'(ov_cnt - ov0), 32'd0);
      check($sformatf("vec%0d busy", v), 32'(busy), 32'h0);
      pulse_ack();
      check($sformatf("vec%0d ack", v), 32'(valid), 32'h0);
    end

    // ---- 4-cycle low glitch: false start ----
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(negedge ipclk);
    rx = 1'b1;
    repeat (2) @(negedge ipclk);
    check("glitch busy during", 32'(busy), 32'h1);
    repeat (6) @(negedge ipclk);
    check("glitch busy after 12", 32'(busy), 32'h0);
    check("glitch valid", 32'(valid), 32'h0);
    check("glitch frame_err", 32'(fe_cnt - fe0), 32'd0);

    // ---- bad stop bit then line held low (break) ----
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (100) @(negedge ipclk);
    check("break frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("break valid", 32'(valid), 32'h0);
    check("break busy", 32'(busy), 32'h1);
    rx = 1'b1;
    repeat (5) @(negedge ipclk);
    check("break released busy", 32'(busy), 32'h0);
    send_frame(8'h55, 1'b1);
    repeat (2) @(negedge ipclk);
    check("after break dataout", 32'(dataout), 32'h55);
    check("after break valid", 32'(valid), 32'h1);
    check("after break frame_err", 32'(fe_cnt - fe0), 32'd1);
    pulse_ack();

    // ---- overrun: second byte arrives with first unconsumed ----
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (2) @(negedge ipclk);
    check("overrun count", 32'(ov_cnt - ov0), 32'd1);
    check("overrun dataout", 32'(dataout), 32'h11);
    check("overrun valid", 32'(valid), 32'h1);
    pulse_ack();
    check("overrun ack", 32'(valid), 32'h0);

    // ---- delivery coinciding with ack ----
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1);
    send_frame_ack_at_stop(8'h22);
    repeat (2) @(negedge ipclk);
    check("coincide dataout", 32'(dataout), 32'h22);
    check("coincide valid", 32'(valid), 32'h1);
    check("coincide overrun", 32'(ov_cnt - ov0), 32'd0);

    // ---- reset during data bit 4 of 0xF0 (byte 0x22 still pending) ----
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx = 1'b0;
    repeat (CPB) @(negedge ipclk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      repeat (CPB) @(negedge ipclk);
    end
    rx = 1'b1;
    repeat (CPB / 2) @(negedge ipclk);
    check("pre-reset busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset dataout", 32'(dataout), 32'h00);
    check("midreset valid", 32'(valid), 32'h0);
    check("midreset busy", 32'(busy), 32'h0);
    check("midreset pulses", 32'(frame_err | overrun), 32'h0);
    repeat (3) @(negedge ipclk);
    rst_n = 1'b1;
    repeat (3) @(negedge ipclk);
    send_frame(8'h0F, 1'b1);
    repeat (2) @(negedge ipclk);
    check("post-reset dataout", 32'(dataout), 32'h0F);
    check("post-reset valid", 32'(valid), 32'h1);
    check("post-reset no pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    pulse_ack();

    // ---- back-to-back 0x00, 0xFF with ack after each ----
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          bit seen = 1'b0;
          for (int i = 0; i < 400; i++) begin
            @(negedge ipclk);
            if (valid === 1'b1) begin
              seen = 1'b1;
              break;
            end
          end
          if (!seen) begin
            check($sformatf("b2b byte%0d timeout", k), 32'h0, 32'h1);
            break;
          end
          got.push_back(dataout);
          pulse_ack();
        end
      end
    join
    check("b2b count", 32'(got.size()), 32'd2);
    if (got.size() == 2) begin
      check("b2b first", 32'(got[0]), 32'h00);
      check("b2b second", 32'(got[1]), 32'hFF);
    end
    repeat (2) @(negedge ipclk);
    check("b2b no error pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    check("b2b valid cleared", 32'(valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_uart_receiver
